// File: rtl/sal_resp_pkg.sv
// Shared types for the SAL response-merge path (read and write return).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state enum, default bus widths, per-beat struct, OKAY code,
// round-robin pointer increment helper.
package sal_resp_pkg;

  // Bank count tracks the DDR2 device bank count.
  localparam int BK_CNT_DEF     = 4;
  localparam int ID_WIDTH_DEF   = 4;
  localparam int DATA_WIDTH_DEF = 64;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // One read beat at the default widths.
  typedef struct packed {
    logic [ID_WIDTH_DEF-1:0]   id;
    logic [DATA_WIDTH_DEF-1:0] data;
    logic                      last;
  } beat_t;

  // Next round-robin position after idx, wrapping cnt-1 -> 0.
  function automatic int rr_inc(input int idx, input int cnt);
    return (idx + 1 >= cnt) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/sal_rd_resp_merger_if.sv
// Bank-side read beats plus the merged AXI R channel, bundled as one bus.
// Latency: n/a (wires only).
// Backpressure: bk_rready / rready handshakes carried through unchanged.
// Ports: bk_rvalid/bk_rready/bk_rid/bk_rdata/bk_rlast per bank;
// rvalid/rready/rid/rdata/rresp/rlast toward the interconnect.
// master = the merger, slave = the banks plus the R-channel consumer.
interface sal_rd_resp_merger_if
  import sal_resp_pkg::*;
#(
  parameter int BK_CNT     = BK_CNT_DEF,
  parameter int ID_WIDTH   = ID_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
  logic [BK_CNT-1:0]                 bk_rvalid;
  logic [BK_CNT-1:0]                 bk_rready;
  logic [BK_CNT-1:0][ID_WIDTH-1:0]   bk_rid;
  logic [BK_CNT-1:0][DATA_WIDTH-1:0] bk_rdata;
  logic [BK_CNT-1:0]                 bk_rlast;

  logic                  rvalid;
  logic                  rready;
  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;

  modport master (
    input  bk_rvalid, bk_rid, bk_rdata, bk_rlast, rready,
    output bk_rready, rvalid, rid, rdata, rresp, rlast
  );

  modport slave (
    output bk_rvalid, bk_rid, bk_rdata, bk_rlast, rready,
    input  bk_rready, rvalid, rid, rdata, rresp, rlast
  );

endinterface

// File: rtl/sal_rr_arbiter.sv
// Round-robin pick: first set request at or after ptr, wrapping modulo N.
// Latency: combinational.
// Backpressure: none; caller decides whether the grant is used.
// Ports: req (N), ptr (index) -> gnt (one-hot), idx (grant index), any.
module sal_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int c;
    c   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      c = int'(ptr) + i;
      if (c >= N) c = c - N;
      if (!any && req[c]) begin
        any = 1'b1;
        idx = IW'(c);
      end
    end
    if (any) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/sal_rd_resp_merger.sv
// Merges per-bank read bursts onto one AXI R channel, round-robin, burst-locked.
// Latency: beat accepted from a bank in cycle N is on R in cycle N+1.
// Backpressure: one-entry output register; rready=0 with rvalid=1 holds it
// and drops every bk_rready. Ports: clk, rst (sync, active-high), bus (master).
module sal_rd_resp_merger
  import sal_resp_pkg::*;
#(
  parameter int BK_CNT     = BK_CNT_DEF,
  parameter int ID_WIDTH   = ID_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  sal_rd_resp_merger_if.master bus
);

  localparam int IDX_W = (BK_CNT > 1) ? $clog2(BK_CNT) : 1;

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
  } rbeat_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;
  logic [IDX_W-1:0] lk, lk_nxt;
  logic [IDX_W-1:0] sel;
  logic [BK_CNT-1:0] rdy;
  logic             load;
  logic             load_ok;
  logic             rvalid_q;
  rbeat_t           out_q;
  rbeat_t           beat_d;

  logic [BK_CNT-1:0] arb_gnt;
  logic [IDX_W-1:0]  arb_idx;
  logic              arb_any;

  sal_rr_arbiter #(.N(BK_CNT), .IW(IDX_W)) u_arb (
    .req (bus.bk_rvalid),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // The output slot can take a beat when empty or being drained this cycle.
  assign load_ok = !rvalid_q || bus.rready;

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    lk_nxt    = lk;
    rdy       = '0;
    load      = 1'b0;
    sel       = arb_idx;
    case (state)
      IDLE: begin
        if (arb_any && load_ok) begin
          rdy  = arb_gnt;
          load = 1'b1;
          if (bus.bk_rlast[arb_idx]) begin
            ptr_nxt = IDX_W'(rr_inc(int'(arb_idx), BK_CNT));
          end else begin
            lk_nxt    = arb_idx;
            state_nxt = BURST;
          end
        end
      end
      BURST: begin
        // Ready for the locked bank depends only on output space, so the
        // bank never sees its own valid looped back into its ready.
        sel     = lk;
        rdy[lk] = load_ok;
        if (load_ok && bus.bk_rvalid[lk]) begin
          load = 1'b1;
          if (bus.bk_rlast[lk]) begin
            ptr_nxt   = IDX_W'(rr_inc(int'(lk), BK_CNT));
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    // A beat handed over during reset would be lost; refuse it instead.
    if (rst) rdy = '0;
  end

  always_comb begin
    beat_d.id   = bus.bk_rid[sel];
    beat_d.data = bus.bk_rdata[sel];
    beat_d.last = bus.bk_rlast[sel];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      lk       <= '0;
      rvalid_q <= 1'b0;
      out_q    <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      lk    <= lk_nxt;
      if (load) begin
        rvalid_q <= 1'b1;
        out_q    <= beat_d;
      end else if (bus.rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  assign bus.bk_rready = rdy;
  assign bus.rvalid    = rvalid_q;
  assign bus.rid       = out_q.id;
  assign bus.rdata     = out_q.data;
  assign bus.rlast     = out_q.last;
  assign bus.rresp     = RESP_OKAY;

endmodule

// File: tb/tb_sal_rd_resp_merger.sv
// Directed bench for sal_rd_resp_merger: bank queues feed beats, R outputs
// and bk_rready are sampled on the falling edge and compared to hand values.
module tb_sal_rd_resp_merger;
  import sal_resp_pkg::*;

  localparam int NB  = 4;
  localparam int IDW = 4;
  localparam int DW  = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sal_rd_resp_merger_if #(.BK_CNT(NB), .ID_WIDTH(IDW), .DATA_WIDTH(DW)) bus ();

  sal_rd_resp_merger #(.BK_CNT(NB), .ID_WIDTH(IDW), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  beat_t q[NB][$];
  logic [NB-1:0] en;

  logic [NB-1:0]  s_rdy, s_fire;
  logic           s_vld, s_last;
  logic [IDW-1:0] s_id;
  logic [DW-1:0]  s_data;
  logic [1:0]     s_resp;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  function automatic logic [DW-1:0] mk(input int b, input int k);
    return 64'hD000_0000_0000_0000 | 64'(b << 8) | 64'(k);
  endfunction

  function automatic logic [IDW-1:0] bid(input int b);
    return IDW'(b + 5);
  endfunction

  task automatic load_burst(input int b, input int n);
    beat_t x;
    for (int k = 0; k < n; k++) begin
      x.id   = bid(b);
      x.data = mk(b, k);
      x.last = (k == n - 1);
      q[b].push_back(x);
    end
  endtask

  task automatic drive();
    for (int b = 0; b < NB; b++) begin
      if (en[b] && q[b].size() > 0) begin
        bus.bk_rvalid[b] = 1'b1;
        bus.bk_rid[b]    = q[b][0].id;
        bus.bk_rdata[b]  = q[b][0].data;
        bus.bk_rlast[b]  = q[b][0].last;
      end else begin
        bus.bk_rvalid[b] = 1'b0;
        bus.bk_rid[b]    = '0;
        bus.bk_rdata[b]  = '0;
        bus.bk_rlast[b]  = 1'b0;
      end
    end
  endtask

  // One clock: sample mid-cycle, then pop whatever the DUT accepted.
  task automatic cycle();
    drive();
    @(negedge clk);
    s_rdy  = bus.bk_rready;
    s_vld  = bus.rvalid;
    s_id   = bus.rid;
    s_data = bus.rdata;
    s_last = bus.rlast;
    s_resp = bus.rresp;
    s_fire = bus.bk_rready & bus.bk_rvalid;
    @(posedge clk);
    #1;
    for (int b = 0; b < NB; b++)
      if (s_fire[b]) void'(q[b].pop_front());
    drive();
  endtask

  task automatic expect_cyc(input string tag, input logic [NB-1:0] rdy, input bit vld,
                            input int b, input int k, input bit last);
    chk({tag, ".bk_rready"}, 64'(s_rdy), 64'(rdy));
    chk({tag, ".rvalid"}, 64'(s_vld), 64'(vld));
    if (vld) begin
      chk({tag, ".rdata"}, s_data, mk(b, k));
      chk({tag, ".rid"}, 64'(s_id), 64'(bid(b)));
      chk({tag, ".rlast"}, 64'(s_last), 64'(last));
      chk({tag, ".rresp"}, 64'(s_resp), 64'd0);
    end
  endtask

  // Stall pattern during one bank-2 burst of three beats.
  int t4_rr[7]   = '{1, 1, 0, 0, 1, 1, 1};
  int t4_rdy[7]  = '{4, 4, 0, 0, 4, 0, 0};
  int t4_vld[7]  = '{0, 1, 1, 1, 1, 1, 0};
  int t4_k[7]    = '{0, 0, 1, 1, 1, 2, 0};

  initial begin
    rst        = 1'b1;
    bus.rready = 1'b1;
    en         = '0;
    drive();
    cycle();
    cycle();
    rst = 1'b0;

    // Reset state.
    cycle();
    expect_cyc("reset", 4'b0000, 1'b0, 0, 0, 1'b0);
    chk("reset.rid", 64'(s_id), 64'd0);
    chk("reset.rdata", s_data, 64'd0);
    chk("reset.rlast", 64'(s_last), 64'd0);

    // All four banks with 2-beat bursts, ptr=0: 0,1,2,3 back to back.
    for (int b = 0; b < NB; b++) load_burst(b, 2);
    en = '1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      expect_cyc($sformatf("all4.c%0d", i),
                 (i < 8) ? NB'(1 << (i / 2)) : NB'(0),
                 (i >= 1 && i <= 8), (i - 1) / 2, (i - 1) % 2, ((i - 1) % 2) == 1);
    end

    // Single bank 0 burst of 4 beats.
    load_burst(0, 4);
    for (int i = 0; i < 6; i++) begin
      cycle();
      expect_cyc($sformatf("b0x4.c%0d", i), (i < 4) ? 4'b0001 : 4'b0000,
                 (i >= 1 && i <= 4), 0, i - 1, (i == 4));
    end

    // Bank 2 raises valid while bank 1 is mid-burst: waits for bank 1 last.
    load_burst(1, 3);
    load_burst(2, 2);
    en = 4'b0010;
    cycle();
    expect_cyc("lock.c0", 4'b0010, 1'b0, 0, 0, 1'b0);
    en = 4'b0110;
    cycle(); expect_cyc("lock.c1", 4'b0010, 1'b1, 1, 0, 1'b0);
    cycle(); expect_cyc("lock.c2", 4'b0010, 1'b1, 1, 1, 1'b0);
    cycle(); expect_cyc("lock.c3", 4'b0100, 1'b1, 1, 2, 1'b1);
    cycle(); expect_cyc("lock.c4", 4'b0100, 1'b1, 2, 0, 1'b0);
    cycle(); expect_cyc("lock.c5", 4'b0000, 1'b1, 2, 1, 1'b1);
    en = '1;

    // Pointer wrap: bank 3 granted last, then banks 0 and 3 -> bank 0 first.
    load_burst(3, 1);
    cycle(); expect_cyc("wrap.c0", 4'b1000, 1'b0, 0, 0, 1'b0);
    load_burst(0, 1);
    load_burst(3, 1);
    cycle(); expect_cyc("wrap.c1", 4'b0001, 1'b1, 3, 0, 1'b1);
    cycle(); expect_cyc("wrap.c2", 4'b1000, 1'b1, 0, 0, 1'b1);
    cycle(); expect_cyc("wrap.c3", 4'b0000, 1'b1, 3, 0, 1'b1);
    cycle(); expect_cyc("wrap.c4", 4'b0000, 1'b0, 0, 0, 1'b0);

    // rready 1,0,0,1 in the middle of a bank 2 burst.
    load_burst(2, 3);
    for (int i = 0; i < 7; i++) begin
      bus.rready = t4_rr[i][0];
      cycle();
      expect_cyc($sformatf("stall.c%0d", i), NB'(t4_rdy[i]), t4_vld[i][0],
                 2, t4_k[i], (t4_k[i] == 2));
    end
    bus.rready = 1'b1;

    // Reset mid-burst (ptr was 3): burst abandoned, ptr back to 0.
    load_burst(1, 4);
    cycle(); expect_cyc("rstmid.c0", 4'b0010, 1'b0, 0, 0, 1'b0);
    cycle(); expect_cyc("rstmid.c1", 4'b0010, 1'b1, 1, 0, 1'b0);
    rst = 1'b1;
    cycle(); expect_cyc("rstmid.c2", 4'b0000, 1'b1, 1, 1, 1'b0);
    rst = 1'b0;
    q[1].delete();
    load_burst(3, 2);
    load_burst(2, 1);
    cycle(); expect_cyc("rstmid.c3", 4'b0100, 1'b0, 0, 0, 1'b0);
    cycle(); expect_cyc("rstmid.c4", 4'b1000, 1'b1, 2, 0, 1'b1);
    cycle(); expect_cyc("rstmid.c5", 4'b1000, 1'b1, 3, 0, 1'b0);
    cycle(); expect_cyc("rstmid.c6", 4'b0000, 1'b1, 3, 1, 1'b1);
    cycle(); expect_cyc("rstmid.c7", 4'b0000, 1'b0, 0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
